// File: rtl/store_narrow.sv
// Store narrowing unit: turns sb/sh/sw requests into word writes against a
// memory without byte enables, using read-modify-write for sub-word stores.
//
// state   | meaning
// IDLE    | ready for a request; capture on req_valid
// READ    | fetch the target word for a sub-word merge
// WRITE   | issue the (merged) word write, pulse done
// ERR     | misaligned or reserved size, pulse err, memory untouched
module store_narrow #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic                  mem_re,
  input  logic [31:0]           mem_rdata,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t                  state, state_nxt;
  logic [1:0]              size_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic                    accept;
  logic                    bad_req;
  logic [31:0]             merged;

  assign accept = (state == S_IDLE) && req_valid;

  always_comb begin
    bad_req = 1'b0;
    case (req_size)
      SZ_BYTE: bad_req = 1'b0;
      SZ_HALF: bad_req = req_addr[0];
      SZ_WORD: bad_req = (req_addr[1:0] != 2'b00);
      default: bad_req = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (bad_req)                  state_nxt = S_ERR;
          else if (req_size == SZ_WORD) state_nxt = S_WRITE;
          else                          state_nxt = S_READ;
        end
      end
      S_READ:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Little-endian lane replacement; untouched lanes pass through from memory.
  always_comb begin
    merged = mem_rdata;
    case (size_q)
      SZ_BYTE: begin
        case (addr_q[1:0])
          2'd0: merged[7:0]   = wdata_q[7:0];
          2'd1: merged[15:8]  = wdata_q[7:0];
          2'd2: merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 32'd0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE:  req_ready = 1'b1;
      S_READ:  mem_re    = 1'b1;
      S_WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = merged;
        done      = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  assign mem_addr = addr_q[ADDR_WIDTH-1:2];

endmodule

// File: tb/tb_store_narrow.sv
// Bench for store_narrow: directed and random stores against a byte-level
// reference memory image, with a word-only synchronous memory model.
module tb_store_narrow;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [29:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;

  logic [31:0] dmem [64];
  logic [7:0]  ref_mem [256];

  store_narrow #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= dmem[mem_addr[5:0]];
    if (mem_we) begin
      dmem[mem_addr[5:0]] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic preload(input int w, input logic [31:0] v);
    dmem[w] = v;
    for (int k = 0; k < 4; k++) ref_mem[4*w+k] = v[8*k +: 8];
  endtask

  // status = {req_ready, mem_re, mem_we, done, err}
  task automatic run_store(input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input string tag);
    logic       exp_err;
    int         nb, w, off;
    logic [7:0] b [4];
    logic [31:0] exp_word;
    logic [29:0] exp_addr;
    nb = 1 << sz;
    exp_err = (sz == 2'd3) || ((a % nb) != 0);
    w = int'(a[7:2]);
    off = int'(a[1:0]);
    exp_addr = a[31:2];
    for (int k = 0; k < 4; k++) b[k] = ref_mem[4*w+k];
    if (!exp_err) for (int k = 0; k < nb; k++) b[off+k] = wd[8*k +: 8];
    exp_word = {b[3], b[2], b[1], b[0]};

    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_c0: got %b want 1", tag, req_ready);
    end
    req_valid = 1'b1; req_size = sz; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
    n_checks++;
    if (mem_addr !== exp_addr) begin
      n_fail++; $display("FAIL %s addr_c1: got %h want %h", tag, mem_addr, exp_addr);
    end
    if (exp_err) begin
      n_checks++;
      if ({req_ready, mem_re, mem_we, done, err} !== 5'b00001 || mem_wdata !== 32'd0) begin
        n_fail++; $display("FAIL %s err_c1: status %b wdata %h want 00001 00000000",
                           tag, {req_ready, mem_re, mem_we, done, err}, mem_wdata);
      end
    end else if (sz == 2'd2) begin
      n_checks++;
      if ({req_ready, mem_re, mem_we, done, err} !== 5'b00110 || mem_wdata !== exp_word) begin
        n_fail++; $display("FAIL %s word_c1: status %b wdata %h want 00110 %h",
                           tag, {req_ready, mem_re, mem_we, done, err}, mem_wdata, exp_word);
      end
    end else begin
      n_checks++;
      if ({req_ready, mem_re, mem_we, done, err} !== 5'b01000 || mem_wdata !== 32'd0) begin
        n_fail++; $display("FAIL %s read_c1: status %b wdata %h want 01000 00000000",
                           tag, {req_ready, mem_re, mem_we, done, err}, mem_wdata);
      end
      @(negedge clk);
      n_checks++;
      if ({req_ready, mem_re, mem_we, done, err} !== 5'b00110 || mem_wdata !== exp_word
          || mem_addr !== exp_addr) begin
        n_fail++; $display("FAIL %s write_c2: status %b wdata %h addr %h want 00110 %h %h",
                           tag, {req_ready, mem_re, mem_we, done, err}, mem_wdata,
                           mem_addr, exp_word, exp_addr);
      end
    end
    if (!exp_err) for (int k = 0; k < 4; k++) ref_mem[4*w+k] = b[k];
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_size = 2'd0; req_addr = 32'd0; req_wdata = 32'd0;
    #1;
    n_checks++;
    if ({req_ready, mem_re, mem_we, done, err} !== 5'b10000 || mem_wdata !== 32'd0
        || mem_addr !== 30'd0) begin
      n_fail++; $display("FAIL reset: status %b wdata %h addr %h want 10000 0 0",
                         {req_ready, mem_re, mem_we, done, err}, mem_wdata, mem_addr);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    preload(1, 32'h1122_3344);
    preload(2, 32'h0102_0304);
    run_store(2'b10, 32'h0000_0010, 32'hDEAD_BEEF, "word");
    run_store(2'b00, 32'h0000_0006, 32'h1234_56AB, "byte_lane2");
    run_store(2'b01, 32'h0000_000A, 32'hFFFF_CAFE, "half_upper");
    run_store(2'b01, 32'h0000_0003, 32'h5555_5555, "err_half");
    run_store(2'b10, 32'h0000_0002, 32'h6666_6666, "err_word");
    run_store(2'b11, 32'h0000_0004, 32'h7777_7777, "err_rsvd");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'hAAAA_0001;
    @(negedge clk);
    req_addr = 32'h24; req_wdata = 32'hBBBB_0002;
    n_checks++;
    if ({req_ready, mem_we, done} !== 3'b011 || mem_wdata !== 32'hAAAA_0001
        || mem_addr !== 30'h8) begin
      n_fail++; $display("FAIL b2b_first: rdy/we/done %b wdata %h addr %h want 011 aaaa0001 8",
                         {req_ready, mem_we, done}, mem_wdata, mem_addr);
    end
    @(negedge clk);
    n_checks++;
    if ({req_ready, mem_re, mem_we, done, err} !== 5'b10000 || mem_addr !== 30'h8) begin
      n_fail++; $display("FAIL b2b_gap: status %b addr %h want 10000 8",
                         {req_ready, mem_re, mem_we, done, err}, mem_addr);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if ({mem_we, done} !== 2'b11 || mem_wdata !== 32'hBBBB_0002 || mem_addr !== 30'h9) begin
      n_fail++; $display("FAIL b2b_second: we/done %b wdata %h addr %h want 11 bbbb0002 9",
                         {mem_we, done}, mem_wdata, mem_addr);
    end
    for (int k = 0; k < 4; k++) begin
      ref_mem[32+k] = 8'(32'hAAAA_0001 >> (8*k));
      ref_mem[36+k] = 8'(32'hBBBB_0002 >> (8*k));
    end
  endtask

  task automatic test_reset_abort();
    int we_snap;
    @(negedge clk);
    req_valid = 1'b1; req_size = 2'b00; req_addr = 32'h31; req_wdata = 32'h0000_00EE;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (mem_re !== 1'b1) begin
      n_fail++; $display("FAIL abort_read: mem_re %b want 1", mem_re);
    end
    we_snap = we_cnt;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, mem_re, mem_we, done, err} !== 5'b10000 || mem_wdata !== 32'd0
        || mem_addr !== 30'd0) begin
      n_fail++; $display("FAIL abort_outputs: status %b wdata %h addr %h want 10000 0 0",
                         {req_ready, mem_re, mem_we, done, err}, mem_wdata, mem_addr);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (we_cnt !== we_snap) begin
      n_fail++; $display("FAIL abort_no_write: writes %0d want %0d", we_cnt, we_snap);
    end
    run_store(2'b10, 32'h0000_0040, 32'h0BAD_F00D, "post_reset_word");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      run_store(2'($urandom_range(0, 3)), 32'($urandom_range(0, 255)), $urandom, "random");
    end
  endtask

  task automatic test_memory_image();
    @(negedge clk);
    for (int w = 0; w < 64; w++) begin
      n_checks++;
      if (dmem[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]}) begin
        n_fail++; $display("FAIL mem_image[%0d]: got %h want %h", w, dmem[w],
                           {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
      end
    end
  endtask

  initial begin
    mem_rdata = 32'd0;
    for (int w = 0; w < 64; w++) preload(w, $urandom);
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_abort();
    test_random();
    test_memory_image();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
